// File: rtl/cabac_intra_luma_mode_rec_pkg.sv
// Shared intra-luma definitions: mode width, named mode constants and the
// reconstruction FSM state encoding.
package cabac_intra_luma_mode_rec_pkg;
  localparam int MODE_W = 6;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t PLANAR = 6'd0;
  localparam mode_t DC     = 6'd1;
  localparam mode_t VER    = 6'd26;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CAND,
    ST_OUT
  } state_e;
endpackage

// File: rtl/cabac_intra_luma_mpm_cand.sv
// Combinational most-probable-mode candidate derivation from left/top
// neighbour modes, plus the ascending sort used for rem-mode expansion.
module cabac_intra_luma_mpm_cand
  import cabac_intra_luma_mode_rec_pkg::*;
(
  input  logic [5:0] left_i,
  input  logic [5:0] top_i,
  output logic [5:0] cand0_o,
  output logic [5:0] cand1_o,
  output logic [5:0] cand2_o,
  output logic [5:0] sort0_o,
  output logic [5:0] sort1_o,
  output logic [5:0] sort2_o
);
  mode_t s0, s1, s2, tmp;

  always_comb begin
    cand0_o = left_i;
    cand1_o = top_i;
    cand2_o = PLANAR;
    if (left_i == top_i) begin
      if (left_i < 6'd2) begin
        cand0_o = PLANAR;
        cand1_o = DC;
        cand2_o = VER;
      end else begin
        // The two angular neighbours of left, wrapping within 2..33.
        cand1_o = ((left_i + 6'd29) & 6'd31) + 6'd2;
        cand2_o = ((left_i - 6'd1) & 6'd31) + 6'd2;
      end
    end else if (left_i != PLANAR && top_i != PLANAR) begin
      cand2_o = PLANAR;
    end else if (left_i + top_i < 6'd2) begin
      cand2_o = VER;
    end else begin
      cand2_o = DC;
    end
  end

  always_comb begin
    s0 = cand0_o;
    s1 = cand1_o;
    s2 = cand2_o;
    tmp = s0;
    if (s0 > s1) begin tmp = s0; s0 = s1; s1 = tmp; end
    if (s1 > s2) begin tmp = s1; s1 = s2; s2 = tmp; end
    if (s0 > s1) begin tmp = s0; s0 = s1; s1 = tmp; end
    sort0_o = s0;
    sort1_o = s1;
    sort2_o = s2;
  end
endmodule

// File: rtl/cabac_intra_luma_mode_rec.sv
// Decoder-side intra luma mode reconstruction: turns decoded flag/value pairs
// into 0..34 luma modes for one 2Nx2N or NxN CU, three cycles per PU.
module cabac_intra_luma_mode_rec
  import cabac_intra_luma_mode_rec_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        part_nxn_i,
  input  logic [5:0]  left_mode0_i,
  input  logic [5:0]  left_mode1_i,
  input  logic [5:0]  top_mode0_i,
  input  logic [5:0]  top_mode1_i,
  input  logic        se_valid_i,
  output logic        se_ready_o,
  input  logic        se_flag_i,
  input  logic [4:0]  se_val_i,
  output logic        mode_valid_o,
  output logic [5:0]  mode_o,
  output logic [1:0]  pu_idx_o,
  output logic        done_o,
  output logic [23:0] cu_modes_o,
  output logic        busy_o,
  output logic        err_o
);
  state_e state_q, state_d;

  logic       nxn_q, flag_q, mode_valid_q, done_q, err_q;
  logic [4:0] val_q;
  logic [1:0] pu_q, pu_out_q, mpm_idx;
  mode_t      l0_q, l1_q, t0_q, t1_q, mode_q;
  mode_t      slot_q [4];
  mode_t      cand_q [3];
  mode_t      sort_q [3];
  mode_t      nb_left, nb_top, rem_mode, mode_d;
  mode_t      c0, c1, c2, s0, s1, s2;
  logic       mpm_err, last_pu;

  // Later PUs of an NxN CU take already-decoded PUs as neighbours.
  always_comb begin
    nb_left = l0_q;
    nb_top  = t0_q;
    case (pu_q)
      2'd1:    begin nb_left = slot_q[0]; nb_top = t1_q;      end
      2'd2:    begin nb_left = l1_q;      nb_top = slot_q[0]; end
      2'd3:    begin nb_left = slot_q[2]; nb_top = slot_q[1]; end
      default: begin nb_left = l0_q;      nb_top = t0_q;      end
    endcase
  end

  cabac_intra_luma_mpm_cand u_cand (
    .left_i  (nb_left),
    .top_i   (nb_top),
    .cand0_o (c0),
    .cand1_o (c1),
    .cand2_o (c2),
    .sort0_o (s0),
    .sort1_o (s1),
    .sort2_o (s2)
  );

  always_comb begin
    mpm_err = flag_q && (val_q[1:0] == 2'd3);
    mpm_idx = mpm_err ? 2'd2 : val_q[1:0];
    rem_mode = {1'b0, val_q};
    for (int i = 0; i < 3; i++) begin
      if (rem_mode >= sort_q[i]) rem_mode = rem_mode + 6'd1;
    end
    case (mpm_idx)
      2'd0:    mode_d = cand_q[0];
      2'd1:    mode_d = cand_q[1];
      default: mode_d = cand_q[2];
    endcase
    if (!flag_q) mode_d = rem_mode;
    last_pu = !nxn_q || (pu_q == 2'd3);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_WAIT;
      ST_WAIT: if (se_valid_i) state_d = ST_CAND;
      ST_CAND: state_d = ST_OUT;
      ST_OUT:  state_d = last_pu ? ST_IDLE : ST_WAIT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nxn_q <= 1'b0; flag_q <= 1'b0; val_q <= '0; pu_q <= '0; pu_out_q <= '0;
      l0_q <= '0; l1_q <= '0; t0_q <= '0; t1_q <= '0; mode_q <= '0;
      mode_valid_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
      for (int k = 0; k < 4; k++) slot_q[k] <= '0;
      for (int k = 0; k < 3; k++) begin cand_q[k] <= '0; sort_q[k] <= '0; end
    end else begin
      mode_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        ST_IDLE: if (start_i) begin
          nxn_q <= part_nxn_i;
          l0_q  <= left_mode0_i;
          l1_q  <= left_mode1_i;
          t0_q  <= top_mode0_i;
          t1_q  <= top_mode1_i;
          pu_q  <= 2'd0;
        end
        ST_WAIT: if (se_valid_i) begin
          flag_q <= se_flag_i;
          val_q  <= se_val_i;
        end
        ST_CAND: begin
          cand_q[0] <= c0; cand_q[1] <= c1; cand_q[2] <= c2;
          sort_q[0] <= s0; sort_q[1] <= s1; sort_q[2] <= s2;
        end
        ST_OUT: begin
          mode_q       <= mode_d;
          mode_valid_q <= 1'b1;
          pu_out_q     <= pu_q;
          err_q        <= mpm_err;
          done_q       <= last_pu;
          for (int k = 0; k < 4; k++) begin
            if (!nxn_q || pu_q == 2'(k)) slot_q[k] <= mode_d;
          end
          if (!last_pu) pu_q <= pu_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign se_ready_o   = (state_q == ST_WAIT);
  assign busy_o       = (state_q != ST_IDLE);
  assign mode_valid_o = mode_valid_q;
  assign mode_o       = mode_q;
  assign pu_idx_o     = pu_out_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign cu_modes_o   = {slot_q[3], slot_q[2], slot_q[1], slot_q[0]};
endmodule

// File: tb/tb_cabac_intra_luma_mode_rec.sv
// Directed bench for cabac_intra_luma_mode_rec with hand-computed expected modes.
module tb_cabac_intra_luma_mode_rec;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0, part_nxn_i = 1'b0;
  logic [5:0]  left_mode0_i = '0, left_mode1_i = '0, top_mode0_i = '0, top_mode1_i = '0;
  logic        se_valid_i = 1'b0, se_flag_i = 1'b0;
  logic [4:0]  se_val_i = '0;
  logic        se_ready_o, mode_valid_o, done_o, busy_o, err_o;
  logic [5:0]  mode_o;
  logic [1:0]  pu_idx_o;
  logic [23:0] cu_modes_o;

  int tests = 0;
  int fails = 0;

  cabac_intra_luma_mode_rec dut (
    .clk(clk), .rst(rst), .start_i(start_i), .part_nxn_i(part_nxn_i),
    .left_mode0_i(left_mode0_i), .left_mode1_i(left_mode1_i),
    .top_mode0_i(top_mode0_i), .top_mode1_i(top_mode1_i),
    .se_valid_i(se_valid_i), .se_ready_o(se_ready_o), .se_flag_i(se_flag_i),
    .se_val_i(se_val_i), .mode_valid_o(mode_valid_o), .mode_o(mode_o),
    .pu_idx_o(pu_idx_o), .done_o(done_o), .cu_modes_o(cu_modes_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, se_ready_o, 0);
    check({tag, "_mv"}, mode_valid_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_mode"}, mode_o, 0);
    check({tag, "_pu"}, pu_idx_o, 0);
    check({tag, "_cu"}, cu_modes_o, 0);
  endtask

  task automatic start_cu(input logic nxn, input logic [5:0] l0, input logic [5:0] l1,
                          input logic [5:0] t0, input logic [5:0] t1);
    start_i = 1'b1; part_nxn_i = nxn;
    left_mode0_i = l0; left_mode1_i = l1; top_mode0_i = t0; top_mode1_i = t1;
    tick();
    start_i = 1'b0;
    left_mode0_i = 6'd63; left_mode1_i = 6'd63; top_mode0_i = 6'd63; top_mode1_i = 6'd63;
    check("start_ready", se_ready_o, 1);
    check("start_busy", busy_o, 1);
  endtask

  // Drives one pair and checks the strobe lands exactly three cycles after accept.
  // With hold set, valid stays high carrying (hf,hv) through CAND/OUT.
  task automatic send_pair(input string tag, input logic f, input logic [4:0] v,
                           input logic [5:0] exp_mode, input logic [1:0] exp_pu,
                           input logic exp_done, input logic exp_err,
                           input bit hold, input logic hf, input logic [4:0] hv);
    int n = 0;
    while (!se_ready_o && n < 20) begin tick(); n++; end
    check({tag, "_ready_wait"}, se_ready_o, 1);
    se_valid_i = 1'b1; se_flag_i = f; se_val_i = v;
    tick();
    if (hold) begin se_flag_i = hf; se_val_i = hv; end
    else se_valid_i = 1'b0;
    check({tag, "_ready_cand"}, se_ready_o, 0);
    check({tag, "_mv_cand"}, mode_valid_o, 0);
    tick();
    check({tag, "_ready_out"}, se_ready_o, 0);
    check({tag, "_mv_out"}, mode_valid_o, 0);
    tick();
    check({tag, "_mv"}, mode_valid_o, 1);
    check({tag, "_mode"}, mode_o, exp_mode);
    check({tag, "_pu"}, pu_idx_o, exp_pu);
    check({tag, "_done"}, done_o, exp_done);
    check({tag, "_err"}, err_o, exp_err);
    check({tag, "_busy"}, busy_o, !exp_done);
    check({tag, "_ready_next"}, se_ready_o, !exp_done);
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    check_idle_outputs("reset");

    // 2Nx2N, equal neighbours below 2: {0,1,26}, mpm_idx 2 -> VER everywhere.
    start_cu(1'b0, 6'd1, 6'd0, 6'd1, 6'd0);
    send_pair("t1", 1'b1, 5'd2, 6'd26, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    check("t1_cu", cu_modes_o, {6'd26, 6'd26, 6'd26, 6'd26});
    tick();
    check("t1_mv_drop", mode_valid_o, 0);
    check("t1_done_drop", done_o, 0);
    check("t1_cu_hold", cu_modes_o, {6'd26, 6'd26, 6'd26, 6'd26});

    // Equal angular neighbours: {10,9,11}.
    start_cu(1'b0, 6'd10, 6'd0, 6'd10, 6'd0);
    send_pair("t2", 1'b1, 5'd1, 6'd9, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);

    // Rem expansion: sorted {0,1,26}, rem 0 -> 2; sorted {2,3,33}, rem 31 -> 34.
    start_cu(1'b0, 6'd0, 6'd0, 6'd26, 6'd0);
    send_pair("t3a", 1'b0, 5'd0, 6'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    start_cu(1'b0, 6'd2, 6'd0, 6'd2, 6'd0);
    send_pair("t3b", 1'b0, 5'd31, 6'd34, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    check("t3b_cu", cu_modes_o, {6'd34, 6'd34, 6'd34, 6'd34});

    // NxN with internal neighbour feedback.
    start_cu(1'b1, 6'd1, 6'd1, 6'd1, 6'd1);
    send_pair("t4_pu0", 1'b1, 5'd0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    send_pair("t4_pu1", 1'b0, 5'd0, 6'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    send_pair("t4_pu2", 1'b1, 5'd1, 6'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    send_pair("t4_pu3", 1'b1, 5'd2, 6'd1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    check("t4_cu", cu_modes_o, {6'd1, 6'd0, 6'd2, 6'd0});

    // Protocol: held valid, mpm_idx 3 clamp, start while busy.
    // PU0 {10,9,11} -> 11 with err; PU1 {11,3,0} rem 5 -> 7;
    // PU2 {26,11,0} rem 20 -> 22; PU3 {22,7,0} mpm 1 -> 7.
    start_cu(1'b1, 6'd10, 6'd26, 6'd10, 6'd3);
    send_pair("t5_pu0", 1'b1, 5'd3, 6'd11, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5);
    send_pair("t5_pu1", 1'b0, 5'd5, 6'd7, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    check("t5_err_drop_cu", cu_modes_o[11:0], {6'd7, 6'd11});
    start_i = 1'b1; part_nxn_i = 1'b0;
    left_mode0_i = 6'd1; left_mode1_i = 6'd1; top_mode0_i = 6'd1; top_mode1_i = 6'd1;
    tick();
    start_i = 1'b0;
    check("t5_start_busy", busy_o, 1);
    check("t5_start_ready", se_ready_o, 1);
    check("t5_err_drop", err_o, 0);
    send_pair("t5_pu2", 1'b0, 5'd20, 6'd22, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    send_pair("t5_pu3", 1'b1, 5'd1, 6'd7, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    check("t5_cu", cu_modes_o, {6'd7, 6'd22, 6'd7, 6'd11});

    // Reset after PU1, then a fresh CU: {5,0,1} sorted {0,1,5}, rem 4 -> 7.
    start_cu(1'b1, 6'd1, 6'd1, 6'd1, 6'd1);
    send_pair("t6_pu0", 1'b1, 5'd0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    send_pair("t6_pu1", 1'b0, 5'd0, 6'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("t6_rst");
    tick(); tick();
    check("t6_no_done", done_o, 0);
    check("t6_still_idle", busy_o, 0);
    start_cu(1'b0, 6'd5, 6'd0, 6'd0, 6'd0);
    send_pair("t6_fresh", 1'b0, 5'd4, 6'd7, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    check("t6_cu", cu_modes_o, {6'd7, 6'd7, 6'd7, 6'd7});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cabac_intra_luma_mode_rec.md
# cabac_intra_luma_mode_rec

- Decoder-side counterpart of the CABAC intra-luma syntax-element preparation.
- Takes decoded `prev_intra_luma_pred_flag` plus `mpm_idx`/`rem_intra_luma_pred_mode` pairs, one per PU, and reconstructs the 6-bit intra luma mode (0..34).
- Neighbour modes come from the CU-level neighbour buffer. Modes reconstructed earlier in the same NxN CU are fed back internally as neighbours.
- Sits between the CABAC bin/syntax decoder and the intra prediction / chroma-mode derivation stage.

## Interface
Parameters: none. Mode width (6) and mode constants come from the shared defines.

- `clk` in 1 — clock
- `rst` in 1 — synchronous, active-high reset
- `start_i` in 1 — one-cycle CU start pulse. Sampled only in IDLE.
- `part_nxn_i` in 1 — 1 = four PUs (NxN); 0 = one PU (2Nx2N). Latched on start.
- `left_mode0_i`, `left_mode1_i` in 6 each — left neighbour modes for the upper and lower PU rows. Latched on start.
- `top_mode0_i`, `top_mode1_i` in 6 each — top neighbour modes for the left and right PU columns. Latched on start.
- `se_valid_i` in 1 — syntax-element pair valid
- `se_ready_o` out 1 — block can accept a pair
- `se_flag_i` in 1 — `prev_intra_luma_pred_flag`
- `se_val_i` in 5 — `mpm_idx` (flag=1, bits [1:0]) or `rem_intra_luma_pred_mode` (flag=0)
- `mode_valid_o` out 1 — one-cycle strobe: `mode_o` is valid
- `mode_o` out 6 — reconstructed luma mode
- `pu_idx_o` out 2 — PU index of `mode_o`
- `done_o` out 1 — one-cycle pulse with the last `mode_valid_o` of the CU
- `cu_modes_o` out 24 — PU3..PU0 modes, with PU0 in [5:0]. Valid from `done_o` until the next accepted start.
- `busy_o` out 1 — high whenever the FSM is not in IDLE
- `err_o` out 1 — one-cycle pulse: `mpm_idx` = 3 was received

## Operation
The FSM has four states.

- **IDLE**
  - On `start_i`: latch partition and neighbours, clear `pu_idx`, go to WAIT.
- **WAIT**
  - `se_ready_o` = 1.
  - On `se_valid_i` && `se_ready_o`: latch flag and value, go to CAND.
- **CAND** — select the current PU's neighbours, derive candidates, register both the candidates and their ascending sort, then go to OUT.
  - Neighbour selection:
    - PU0: left = L0, top = T0
    - PU1: left = PU0, top = T1
    - PU2: left = L1, top = PU0
    - PU3: left = PU2, top = PU1
  - Candidate derivation:
    - If left == top and left < 2: {0, 1, 26}.
    - If left == top and left ≥ 2: {left, ((left+29)&31)+2, ((left−1)&31)+2}. Arithmetic is 6-bit.
    - If left != top: {left, top, X}.
      - X = 0 if neither neighbour is 0.
      - Otherwise X = 26 if left+top < 2.
      - Otherwise X = 1.
- **OUT** — compute the mode and register it with its strobe.
  - flag = 1: mode = cand[mpm_idx]. `mpm_idx` = 3 is clamped to 2 and `err_o` pulses.
  - flag = 0: m = rem, then for i = 0..2 in sorted order, m = m + 1 if m ≥ sorted[i]. The result is 0..34 in 6 bits.
  - Store the mode in PU slot `pu_idx`.
    - For 2Nx2N, write the mode to all four slots.
  - If this was the last PU, pulse `done_o` and go to IDLE.
  - Otherwise increment `pu_idx` and go to WAIT.

Input rules:
- `start_i` while `busy_o` is high is ignored.
- `se_valid_i` outside WAIT is not accepted. The upstream holds the pair until ready.
- Neighbour inputs are don't-care after the start cycle.

## Timing
- Reset values: `se_ready_o`, `mode_valid_o`, `done_o`, `busy_o`, `err_o` = 0; `mode_o`, `pu_idx_o`, `cu_modes_o` = 0; FSM = IDLE.
- Latency:
  - Start accepted at cycle S: `se_ready_o` = 1 at S+1.
  - Pair accepted at cycle T: `mode_valid_o` at T+3.
- Throughput: 3 cycles per PU. `se_ready_o` reasserts in the same cycle as `mode_valid_o`, so the next pair can be accepted at T+3.
- `done_o` and `cu_modes_o` update in the same cycle as the last `mode_valid_o`. `busy_o` falls in that same cycle.
- A new `start_i` is accepted one cycle after `done_o` or later.
- All outputs are registered. There is no output backpressure.
- Reset mid-CU: return to IDLE, emit no `done_o`, clear `cu_modes_o`.

## Structure
- Shared defines (the common defines file):
  - Mode width 6
  - `PLANAR` = 0, `DC` = 1, `VER` = 26
- One sub-module, `cabac_intra_luma_mpm_cand`:
  - Purely combinational.
  - Maps left/top to three candidates plus their ascending sort.
  - Reusable by the encoder-side prepare block.
- This block holds the FSM, the latched neighbours, the PU mode slots and the rem-expansion logic.

## Test plan
1. 2Nx2N, L0 = T0 = 1, pair (1, 2) → `mode_o` = 26 three cycles after accept; `done_o` = 1; `cu_modes_o` holds 26 in all four slots.
2. 2Nx2N, L0 = T0 = 10, pair (1, 1) → candidates {10, 9, 11}; `mode_o` = 9.
3. 2Nx2N, L0 = 0, T0 = 26, pair (0, 0) → sorted {0, 1, 26}; `mode_o` = 2. Then L0 = T0 = 2, pair (0, 31) → sorted {2, 3, 33}; `mode_o` = 34.
4. NxN, all neighbours 1. Pairs (1,0), (0,0), (1,1), (1,2) → modes 0, 2, 0, 1; `pu_idx_o` 0..3; `done_o` only with PU3; `cu_modes_o` = {1, 0, 2, 0}.
5. Protocol checks:
   - `se_valid_i` held high during CAND/OUT → no extra accept.
   - `start_i` while busy → ignored.
   - Pair (1, 3) → `mode_o` = cand[2] and `err_o` pulses.
6. `rst` asserted after PU1 of an NxN CU → all outputs at reset values next cycle; no `done_o`; a fresh CU then decodes correctly.
